// File: rtl/rd_ptr_empty_ctrl.sv
// Read-side pointer and status controller for an async FIFO (read clock domain).
// Synchronises the write gray pointer and produces registered empty/almost-empty/level/underflow.
module rd_ptr_empty_ctrl #(
    parameter int ADDR_SIZE   = 4,
    parameter int SYNC_STAGES = 2,
    parameter int AE_THRESH   = 2
) (
    input  logic                 r_clk,
    input  logic                 r_rst,
    input  logic [ADDR_SIZE:0]   w_ptr_gray,
    input  logic                 r_en,
    input  logic                 r_underflow_clr,
    output logic [ADDR_SIZE:0]   r_ptr_gray,
    output logic [ADDR_SIZE-1:0] r_addr,
    output logic                 r_empty,
    output logic                 r_almost_empty,
    output logic [ADDR_SIZE:0]   r_level,
    output logic                 r_underflow
);

    localparam int DEPTH = 1 << ADDR_SIZE;
    localparam logic [ADDR_SIZE:0] AE_LIM = (ADDR_SIZE+1)'(AE_THRESH);

    if (SYNC_STAGES < 2) begin : g_chk_sync
        $error("rd_ptr_empty_ctrl: SYNC_STAGES must be >= 2");
    end
    if (AE_THRESH < 0 || AE_THRESH >= DEPTH) begin : g_chk_ae
        $error("rd_ptr_empty_ctrl: AE_THRESH must be in 0..DEPTH-1");
    end

    logic [ADDR_SIZE:0] sync_q [SYNC_STAGES];
    logic [ADDR_SIZE:0] wq_gray;
    logic [ADDR_SIZE:0] wq_bin;

    logic [ADDR_SIZE:0] ptr_bin_q,  ptr_bin_d;
    logic [ADDR_SIZE:0] ptr_gray_q, ptr_gray_d;
    logic [ADDR_SIZE:0] level_q,    level_d;
    logic               empty_q,    empty_d;
    logic               ae_q,       ae_d;
    logic               underflow_q, underflow_d;
    logic               rd_fire;

    always_ff @(posedge r_clk or negedge r_rst) begin
        if (!r_rst) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= w_ptr_gray;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign wq_gray = sync_q[SYNC_STAGES-1];

    // Bit i of the binary value is the XOR of gray bits i..MSB.
    for (genvar i = 0; i <= ADDR_SIZE; i++) begin : g_g2b
        assign wq_bin[i] = ^(wq_gray >> i);
    end

    always_comb begin
        rd_fire     = r_en & ~empty_q;
        ptr_bin_d   = ptr_bin_q + {{ADDR_SIZE{1'b0}}, rd_fire};
        ptr_gray_d  = ptr_bin_d ^ (ptr_bin_d >> 1);
        empty_d     = (ptr_gray_d == wq_gray);
        level_d     = wq_bin - ptr_bin_d;
        ae_d        = (level_d <= AE_LIM);
        underflow_d = (r_en & empty_q) | (underflow_q & ~r_underflow_clr);
    end

    always_ff @(posedge r_clk or negedge r_rst) begin
        if (!r_rst) begin
            ptr_bin_q   <= '0;
            ptr_gray_q  <= '0;
            level_q     <= '0;
            empty_q     <= 1'b1;
            ae_q        <= 1'b1;
            underflow_q <= 1'b0;
        end else begin
            ptr_bin_q   <= ptr_bin_d;
            ptr_gray_q  <= ptr_gray_d;
            level_q     <= level_d;
            empty_q     <= empty_d;
            ae_q        <= ae_d;
            underflow_q <= underflow_d;
        end
    end

    assign r_ptr_gray     = ptr_gray_q;
    assign r_addr         = ptr_bin_q[ADDR_SIZE-1:0];
    assign r_empty        = empty_q;
    assign r_almost_empty = ae_q;
    assign r_level        = level_q;
    assign r_underflow    = underflow_q;

endmodule

// File: tb/tb_rd_ptr_empty_ctrl.sv
// Directed bench for rd_ptr_empty_ctrl with default parameters (DEPTH=16, 2 sync stages, AE_THRESH=2).
module tb_rd_ptr_empty_ctrl;

    logic       r_clk = 1'b0;
    logic       r_rst;
    logic [4:0] w_ptr_gray;
    logic       r_en;
    logic       r_underflow_clr;
    logic [4:0] r_ptr_gray;
    logic [3:0] r_addr;
    logic       r_empty;
    logic       r_almost_empty;
    logic [4:0] r_level;
    logic       r_underflow;

    int checks = 0;
    int fails  = 0;

    rd_ptr_empty_ctrl #(
        .ADDR_SIZE   (4),
        .SYNC_STAGES (2),
        .AE_THRESH   (2)
    ) dut (
        .r_clk           (r_clk),
        .r_rst           (r_rst),
        .w_ptr_gray      (w_ptr_gray),
        .r_en            (r_en),
        .r_underflow_clr (r_underflow_clr),
        .r_ptr_gray      (r_ptr_gray),
        .r_addr          (r_addr),
        .r_empty         (r_empty),
        .r_almost_empty  (r_almost_empty),
        .r_level         (r_level),
        .r_underflow     (r_underflow)
    );

    always #5 r_clk = ~r_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] gray5(input int unsigned v);
        logic [4:0] b;
        b = v[4:0];
        return b ^ (b >> 1);
    endfunction

    task automatic tick();
        @(posedge r_clk);
        @(negedge r_clk);
    endtask

    task automatic do_reset();
        r_rst           = 1'b0;
        w_ptr_gray      = '0;
        r_en            = 1'b0;
        r_underflow_clr = 1'b0;
        tick();
        r_rst = 1'b1;
    endtask

    task automatic check_all(input string tag, input logic emp, input logic ae,
                             input logic [4:0] lvl, input logic [4:0] pg,
                             input logic [3:0] addr, input logic uf);
        check_eq({tag, ".empty"}, 32'(r_empty), 32'(emp));
        check_eq({tag, ".ae"},    32'(r_almost_empty), 32'(ae));
        check_eq({tag, ".level"}, 32'(r_level), 32'(lvl));
        check_eq({tag, ".pgray"}, 32'(r_ptr_gray), 32'(pg));
        check_eq({tag, ".addr"},  32'(r_addr), 32'(addr));
        check_eq({tag, ".uf"},    32'(r_underflow), 32'(uf));
    endtask

    initial begin
        int unsigned lvl;
        int unsigned n;

        // 1: reset holds outputs regardless of the incoming write pointer
        r_rst = 1'b0; r_en = 1'b0; r_underflow_clr = 1'b0;
        w_ptr_gray = 5'b00011;
        @(negedge r_clk);
        tick();
        check_all("reset", 1'b1, 1'b1, 5'd0, 5'd0, 4'd0, 1'b0);
        w_ptr_gray = '0;
        r_rst = 1'b1;

        // 2: single write seen after exactly 3 edges, then one read
        w_ptr_gray = gray5(1);
        tick();
        check_eq("wr1.edge1.empty", 32'(r_empty), 32'd1);
        tick();
        check_eq("wr1.edge2.empty", 32'(r_empty), 32'd1);
        tick();
        check_all("wr1.edge3", 1'b0, 1'b1, 5'd1, 5'd0, 4'd0, 1'b0);
        r_en = 1'b1;
        tick();
        r_en = 1'b0;
        check_all("rd1", 1'b1, 1'b1, 5'd0, 5'd1, 4'd1, 1'b0);

        // 3: fill to 16, level trails the write pointer by 3 cycles
        do_reset();
        for (int k = 1; k <= 19; k++) begin
            lvl = (k > 3) ? (k - 3) : 0;
            check_eq($sformatf("fill%0d.level", k), 32'(r_level), lvl);
            check_eq($sformatf("fill%0d.ae", k), 32'(r_almost_empty), 32'(lvl <= 2));
            check_eq($sformatf("fill%0d.empty", k), 32'(r_empty), 32'(lvl == 0));
            w_ptr_gray = gray5((k > 16) ? 16 : k);
            tick();
        end
        for (int l = 16; l >= 1; l--) begin
            r_en = 1'b1;
            tick();
            check_eq($sformatf("drain%0d.level", l - 1), 32'(r_level), 32'(l - 1));
            check_eq($sformatf("drain%0d.ae", l - 1), 32'(r_almost_empty), 32'((l - 1) <= 2));
            check_eq($sformatf("drain%0d.empty", l - 1), 32'(r_empty), 32'(l == 1));
        end
        r_en = 1'b0;
        check_eq("drain.pgray", 32'(r_ptr_gray), 32'(gray5(16)));

        // 4: streaming 40 writes/reads, one per cycle, across two MSB toggles
        do_reset();
        for (int e = 1; e <= 46; e++) begin
            w_ptr_gray = gray5((e > 40) ? 40 : e);
            r_en = (e >= 4 && e <= 43);
            tick();
            n   = (e <= 3) ? 0 : ((e >= 44) ? 40 : e - 3);
            lvl = (e >= 3 && e <= 42) ? 1 : 0;
            check_all($sformatf("wrap%0d", e), (lvl == 0), 1'b1, lvl[4:0],
                      gray5(n), n[3:0], 1'b0);
        end
        r_en = 1'b0;

        // 5: underflow is sticky; set beats clear
        r_en = 1'b1;
        tick();
        check_all("uf.set", 1'b1, 1'b1, 5'd0, gray5(40), 4'd8, 1'b1);
        r_underflow_clr = 1'b1;
        tick();
        check_eq("uf.setwins", 32'(r_underflow), 32'd1);
        check_eq("uf.setwins.pgray", 32'(r_ptr_gray), 32'(gray5(40)));
        r_en = 1'b0;
        tick();
        check_eq("uf.clr", 32'(r_underflow), 32'd0);
        r_underflow_clr = 1'b0;

        // 6: asynchronous reset mid-cycle with data in flight
        do_reset();
        w_ptr_gray = gray5(8);
        tick(); tick(); tick();
        check_eq("pre.level8", 32'(r_level), 32'd8);
        r_en = 1'b1;
        r_underflow_clr = 1'b0;
        tick();
        r_en = 1'b0;
        check_all("pre.rst", 1'b0, 1'b0, 5'd7, 5'd1, 4'd1, 1'b0);
        @(posedge r_clk);
        #2 r_rst = 1'b0;
        #1;
        check_all("midrst", 1'b1, 1'b1, 5'd0, 5'd0, 4'd0, 1'b0);
        @(negedge r_clk);
        r_rst = 1'b1;
        tick(); tick(); tick();
        check_eq("postrst.level", 32'(r_level), 32'd8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
